// File: rtl/ppe_rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encoding and index-width helper.
package ppe_rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Smallest r with 2**r >= v. Usable in parameter expressions.
    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ppe_mask_pe.sv
// Masked lowest-set-bit priority encoder: bits at or above ptr win, else wrap to lowest request.
// Latency: purely combinational.
// Backpressure: none, evaluates every cycle.
module ppe_mask_pe
    import ppe_rr_arb_pkg::*;
#(
    parameter int W  = 256,
    localparam int IW = clog2_f(W)
) (
    input  logic [W-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [W-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [W-1:0] masked;
    logic [W-1:0] sel;

    always_comb begin
        masked = '0;
        for (int i = 0; i < W; i++) begin
            masked[i] = req[i] && (i >= int'(ptr));
        end
        // Nothing at or above ptr: fall back to the full vector, giving the cyclic wrap.
        sel    = (|masked) ? masked : req;
        onehot = sel & (~sel + 1'b1);
        idx    = '0;
        for (int i = 0; i < W; i++) begin
            if (onehot[i]) idx = idx | IW'(i);
        end
        any    = |req;
    end

endmodule

// File: rtl/ppe_rr_arb.sv
// Round-robin / programmable-priority arbiter holding one grant until ack or abandon.
// Latency: grant registered one cycle after req is sampled; one idle bubble after each release.
// Backpressure: a held grant blocks all other requesters until gnt_ack or the holder drops req.
module ppe_rr_arb
    import ppe_rr_arb_pkg::*;
#(
    parameter int W       = 256,
    parameter int RR_MODE = 1,
    localparam int IW     = clog2_f(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  req,
    input  logic          gnt_ack,
    input  logic          prio_load,
    input  logic [IW-1:0] prio_val,
    output logic [W-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld,
    output logic [IW-1:0] ptr
);

    state_t        state_q, state_d;
    logic [W-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic [W-1:0]  pe_onehot;
    logic [IW-1:0] pe_idx;
    logic          pe_any;
    logic          release_gnt;

    ppe_mask_pe #(.W(W)) u_pe (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pe_onehot),
        .idx    (pe_idx),
        .any    (pe_any)
    );

    // Holder either acknowledges or abandons by dropping its own request.
    assign release_gnt = gnt_ack || !req[idx_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pe_any)      state_d = HOLD;
            HOLD:    if (release_gnt) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d = gnt_q;
        idx_d = idx_q;
        ptr_d = ptr_q;
        case (state_q)
            IDLE: begin
                gnt_d = pe_any ? pe_onehot : '0;
                idx_d = pe_any ? pe_idx    : '0;
            end
            HOLD: begin
                if (release_gnt) begin
                    gnt_d = '0;
                    idx_d = '0;
                    if (gnt_ack && RR_MODE == 1) ptr_d = idx_q + 1'b1;
                end
            end
            default: begin
                gnt_d = '0;
                idx_d = '0;
            end
        endcase
        // A software load wins over a concurrent round-robin advance.
        if (prio_load) ptr_d = prio_val;
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = (state_q == HOLD);
    assign ptr     = ptr_q;

endmodule

// File: tb/tb_ppe_rr_arb.sv
// Directed bench for ppe_rr_arb: one round-robin instance and one fixed-priority instance, W=8.
module tb_ppe_rr_arb;

    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] req, gnt;
    logic       gnt_ack, prio_load, gnt_vld;
    logic [2:0] prio_val, gnt_idx, ptr;

    logic [7:0] req_b, gnt_b;
    logic       ack_b, load_b, vld_b;
    logic [2:0] val_b, idx_b, ptr_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ppe_rr_arb #(.W(8), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .req(req), .gnt_ack(gnt_ack),
        .prio_load(prio_load), .prio_val(prio_val),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .ptr(ptr)
    );

    ppe_rr_arb #(.W(8), .RR_MODE(0)) dut_fx (
        .clk(clk), .rst(rst), .req(req_b), .gnt_ack(ack_b),
        .prio_load(load_b), .prio_val(val_b),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b), .ptr(ptr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; gnt_ack = 0; prio_load = 0; prio_val = '0;
        req_b = '0; ack_b = 0; load_b = 0; val_b = '0;
        #3;
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_vld", gnt_vld, 1'b0);
        chk("rst_ptr", ptr, 3'd0);
        chk("rst_idx", gnt_idx, 3'd0);
        step(); step();
        rst = 1'b0;

        // Idle with no requests, then first grant
        step();
        chk("idle_vld", gnt_vld, 1'b0);
        chk("idle_gnt", gnt, 8'h00);
        req = 8'h12;
        step();
        chk("first_gnt", gnt, 8'h02);
        chk("first_idx", gnt_idx, 3'd1);
        chk("first_vld", gnt_vld, 1'b1);
        gnt_ack = 1;
        step();
        chk("first_rel_vld", gnt_vld, 1'b0);
        chk("first_rel_ptr", ptr, 3'd2);
        gnt_ack = 0; req = '0;

        // Round robin over a full request vector, starting from pointer 0
        prio_load = 1; prio_val = 3'd0;
        step();
        chk("rr_load_ptr", ptr, 3'd0);
        prio_load = 0; req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("rr_vld", gnt_vld, 1'b1);
            chk("rr_idx", gnt_idx, k % 8);
            chk("rr_gnt", gnt, 32'(1 << (k % 8)));
            gnt_ack = 1;
            step();
            chk("rr_bubble", gnt_vld, 1'b0);
            chk("rr_ptr", ptr, (k + 1) % 8);
            gnt_ack = 0;
        end

        // Hold stability and abandon
        req = '0; prio_load = 1; prio_val = 3'd3;
        step();
        chk("hold_load_ptr", ptr, 3'd3);
        chk("hold_load_vld", gnt_vld, 1'b0);
        prio_load = 0; req = 8'h08;
        step();
        chk("hold_gnt", gnt, 8'h08);
        chk("hold_idx", gnt_idx, 3'd3);
        req = 8'h0C;
        step();
        chk("hold_stable_gnt", gnt, 8'h08);
        chk("hold_stable_vld", gnt_vld, 1'b1);
        req = 8'hF0;
        step();
        chk("abandon_vld", gnt_vld, 1'b0);
        chk("abandon_gnt", gnt, 8'h00);
        chk("abandon_ptr", ptr, 3'd3);
        gnt_ack = 1;
        step();
        chk("regrant_gnt", gnt, 8'h10);
        chk("regrant_idx", gnt_idx, 3'd4);
        chk("idle_ack_ignored_ptr", ptr, 3'd3);
        step();
        chk("ack4_vld", gnt_vld, 1'b0);
        chk("ack4_ptr", ptr, 3'd5);
        gnt_ack = 0;

        // Collision of load and advancing ack
        req = 8'h40;
        step();
        chk("col_gnt", gnt, 8'h40);
        chk("col_idx", gnt_idx, 3'd6);
        gnt_ack = 1; prio_load = 1; prio_val = 3'd2;
        step();
        chk("col_vld", gnt_vld, 1'b0);
        chk("col_ptr", ptr, 3'd2);
        gnt_ack = 0; prio_load = 0;

        // Asynchronous reset during HOLD
        step();
        chk("pre_rst_gnt", gnt, 8'h40);
        chk("pre_rst_vld", gnt_vld, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_gnt", gnt, 8'h00);
        chk("arst_vld", gnt_vld, 1'b0);
        chk("arst_idx", gnt_idx, 3'd0);
        chk("arst_ptr", ptr, 3'd0);
        step();
        rst = 1'b0; req = 8'h81;
        step();
        chk("post_rst_gnt", gnt, 8'h01);
        chk("post_rst_idx", gnt_idx, 3'd0);
        req = '0;

        // Fixed programmable priority instance
        load_b = 1; val_b = 3'd5;
        step();
        chk("fx_load_ptr", ptr_b, 3'd5);
        load_b = 0; req_b = 8'h21;
        step();
        chk("fx_gnt", gnt_b, 8'h20);
        chk("fx_idx", idx_b, 3'd5);
        ack_b = 1;
        step();
        chk("fx_rel_vld", vld_b, 1'b0);
        chk("fx_rel_ptr", ptr_b, 3'd5);
        ack_b = 0;
        step();
        chk("fx_regrant_gnt", gnt_b, 8'h20);
        chk("fx_regrant_ptr", ptr_b, 3'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
